ultrasonic_echo_emulator: RTL and testbench

ULTRASONIC_ECHO_EMULATOR -- requirements
Module: ultrasonic_echo_emulator

---
 rtl/ultrasonic_echo_emulator.sv | 172 +++++++++++++++++
 tb/tb_ultrasonic_echo_emulator.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_emulator.sv
// Ultrasonic ranging sensor echo emulator (trigger in, echo pulse out).
// Optional macro ECHO_STATS_EN adds the 16-bit echo_cnt output.
module ultrasonic_echo_emulator #(
    parameter int TICKS_PER_US = 50,
    parameter int TRIG_MIN_US  = 10,
    parameter int BURST_US     = 200,
    parameter int MAX_CM       = 400,
    parameter int TIMEOUT_US   = 38000,
    parameter int HOLDOFF_US   = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy
`ifdef ECHO_STATS_EN
    ,
    output logic [15:0] echo_cnt
`endif
);

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_US - 1);
    localparam logic [15:0]   TRIG_MIN  = 16'(TRIG_MIN_US);
    localparam logic [15:0]   BURST_LEN = 16'(BURST_US);
    localparam logic [15:0]   HOLD_LEN  = 16'(HOLDOFF_US);
    localparam logic [15:0]   TIMEOUT   = 16'(TIMEOUT_US);
    localparam logic [15:0]   MAXD      = 16'(MAX_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          trig_s1;
    logic          trig_s2;
    logic          trig_d;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [PW-1:0] pre;
    logic [15:0]   us;
    logic [15:0]   us_inc;
    logic [15:0]   width_us;
    logic [15:0]   width_nxt;

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign rise   = trig_s2 & ~trig_d;
    assign fall   = ~trig_s2 & trig_d;
    assign tick   = (pre == PRE_LAST);
    assign us_inc = us + 16'd1;

    // Echo width in us from the current distance input
    always_comb begin
        width_nxt = TIMEOUT;
        if ((dist_cm != 9'd0) && ({7'd0, dist_cm} <= MAXD)) begin
            width_nxt = {7'd0, dist_cm} * 16'd58;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; timed states leave on the tick that completes the count
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = TRIG_HI;
                end
            end
            TRIG_HI: begin
                if (fall) begin
                    state_nxt = (us >= TRIG_MIN) ? BURST : IDLE;
                end
            end
            BURST: begin
                if (tick && (us_inc == BURST_LEN)) begin
                    state_nxt = ECHO;
                end
            end
            ECHO: begin
                if (tick && (us_inc == width_us)) begin
                    state_nxt = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (tick && (us_inc == HOLD_LEN)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Prescaler and saturating us counter, cleared on every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            us  <= 16'd0;
        end else if (state_nxt != state) begin
            pre <= '0;
            us  <= 16'd0;
        end else if (tick) begin
            pre <= '0;
            if (us != 16'hFFFF) begin
                us <= us_inc;
            end
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Width is captured once, as the accepted trigger enters BURST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_us <= 16'd0;
        end else if ((state == TRIG_HI) && (state_nxt == BURST)) begin
            width_us <= width_nxt;
        end
    end

    // Registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo <= 1'b0;
            busy <= 1'b0;
        end else begin
            echo <= (state_nxt == ECHO);
            busy <= (state_nxt != IDLE);
        end
    end

`ifdef ECHO_STATS_EN
    // Count completed echoes, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_cnt <= 16'd0;
        end else if ((state == ECHO) && (state_nxt == HOLDOFF)) begin
            echo_cnt <= echo_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ultrasonic_echo_emulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [8:0] dist_cm = 9'd0;
    logic       echo;
    logic       busy;
`ifdef ECHO_STATS_EN
    logic [15:0] echo_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Short timeout keeps the no-object runs brief: 300 us -> 600 clk
    ultrasonic_echo_emulator #(
        .TICKS_PER_US(2),
        .TRIG_MIN_US (10),
        .BURST_US    (4),
        .MAX_CM      (400),
        .TIMEOUT_US  (300),
        .HOLDOFF_US  (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .trig   (trig),
        .dist_cm(dist_cm),
        .echo   (echo),
        .busy   (busy)
`ifdef ECHO_STATS_EN
        ,
        .echo_cnt(echo_cnt)
`endif
    );

    // Pulse trig for hi clk, then time echo rise, echo width, busy tail.
    // rd = -1 when no echo appears within 40 clk.
    task automatic run_meas(input int hi, output int rd,
                            output int w, output int tl);
        trig = 1'b1;
        repeat (hi) @(negedge clk);
        trig = 1'b0;
        rd = 0;
        w = 0;
        tl = 0;
        while (!echo && rd < 40) begin
            @(negedge clk);
            rd++;
        end
        if (!echo) begin
            rd = -1;
            return;
        end
        while (echo && w < 3000) begin
            @(negedge clk);
            w++;
        end
        while (busy && tl < 100) begin
            @(negedge clk);
            tl++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trig = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (echo !== 1'b0) $display("FAIL reset_echo: got %b want 0", echo);
        if (echo !== 1'b0) failures++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        if (busy !== 1'b0) failures++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || echo !== 1'b0) begin
            $display("FAIL idle_after_reset: busy=%b echo=%b want 0 0",
                     busy, echo);
            failures++;
        end
    endtask

    // 12 us trigger, 10 cm: 2 sync + 1 detect + 8 burst = 11 clk to rise
    task automatic test_basic();
        int rd, w, tl;
        dist_cm = 9'd10;
        run_meas(24, rd, w, tl);
        checks++;
        if (rd != 11) begin
            $display("FAIL basic_rise: got %0d want 11", rd);
            failures++;
        end
        checks++;
        if (w != 1160) begin
            $display("FAIL basic_width: got %0d want 1160", w);
            failures++;
        end
        checks++;
        if (tl != 12) begin
            $display("FAIL basic_holdoff: got %0d want 12", tl);
            failures++;
        end
        repeat (5) @(negedge clk);
    endtask

    // 11 us pulse measures 10 us in TRIG_HI (accepted); 9 us gives 8 us
    task automatic test_trig_min();
        int rd, w, tl;
        dist_cm = 9'd1;
        run_meas(22, rd, w, tl);
        checks++;
        if (rd != 11 || w != 116) begin
            $display("FAIL min_accept: rise=%0d width=%0d want 11 116", rd, w);
            failures++;
        end
        repeat (5) @(negedge clk);
        run_meas(18, rd, w, tl);
        checks++;
        if (rd != -1) begin
            $display("FAIL min_reject: rise=%0d want -1", rd);
            failures++;
        end
        repeat (5) @(negedge clk);
    endtask

    // 6 us trigger: rejected, busy drops as FSM sees the fall
    task automatic test_short();
        int seen;
        dist_cm = 9'd10;
        trig = 1'b1;
        repeat (12) @(negedge clk);
        trig = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL short_busy_hi: got %b want 1", busy);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL short_busy_lo: got %b want 0", busy);
            failures++;
        end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (echo !== 1'b0) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL short_no_echo: got %0d want 0", seen);
            failures++;
        end
    endtask

    // No object and out-of-range both give the timeout width
    task automatic test_timeout();
        int rd, w, tl;
        dist_cm = 9'd0;
        run_meas(24, rd, w, tl);
        checks++;
        if (w != 600) begin
            $display("FAIL timeout_zero: got %0d want 600", w);
            failures++;
        end
        repeat (5) @(negedge clk);
        dist_cm = 9'd401;
        run_meas(24, rd, w, tl);
        checks++;
        if (w != 600) begin
            $display("FAIL timeout_401: got %0d want 600", w);
            failures++;
        end
        repeat (5) @(negedge clk);
    endtask

    // Distance change and a second trigger during ECHO are ignored
    task automatic test_mid_echo();
        int rd, w, tl, seen;
        dist_cm = 9'd17;
        trig = 1'b1;
        repeat (24) @(negedge clk);
        trig = 1'b0;
        rd = 0;
        while (!echo && rd < 40) begin
            @(negedge clk);
            rd++;
        end
        w = 0;
        while (echo && w < 3000) begin
            @(negedge clk);
            w++;
            if (w == 100) begin
                dist_cm = 9'd3;
                trig = 1'b1;
            end
            if (w == 124) trig = 1'b0;
        end
        checks++;
        if (w != 1972) begin
            $display("FAIL mid_echo_width: got %0d want 1972", w);
            failures++;
        end
        tl = 0;
        while (busy && tl < 100) begin
            @(negedge clk);
            tl++;
        end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (echo !== 1'b0) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL mid_echo_single: got %0d want 0", seen);
            failures++;
        end
    endtask

    // trig raised in ECHO and still high in IDLE must not start a cycle
    task automatic test_rearm();
        int rd, w, tl, bad;
        dist_cm = 9'd5;
        trig = 1'b1;
        repeat (24) @(negedge clk);
        trig = 1'b0;
        rd = 0;
        while (!echo && rd < 40) begin
            @(negedge clk);
            rd++;
        end
        trig = 1'b1;
        repeat (600) @(negedge clk);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || echo !== 1'b0) bad = 1;
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL rearm_held_high: got %0d want 0", bad);
            failures++;
        end
        trig = 1'b0;
        repeat (10) @(negedge clk);
        run_meas(24, rd, w, tl);
        checks++;
        if (w != 580) begin
            $display("FAIL rearm_width: got %0d want 580", w);
            failures++;
        end
        repeat (5) @(negedge clk);
    endtask

    // trig stuck high holds TRIG_HI with echo low
    task automatic test_trig_hold();
        int bad, rd, w;
        dist_cm = 9'd2;
        trig = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (echo !== 1'b0) bad = 1;
        end
        checks++;
        if (bad != 0 || busy !== 1'b1) begin
            $display("FAIL hold_high: echo_seen=%0d busy=%b want 0 1",
                     bad, busy);
            failures++;
        end
        trig = 1'b0;
        rd = 0;
        while (!echo && rd < 40) begin
            @(negedge clk);
            rd++;
        end
        w = 0;
        while (echo && w < 3000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rd != 11 || w != 232) begin
            $display("FAIL hold_release: rise=%0d width=%0d want 11 232",
                     rd, w);
            failures++;
        end
        repeat (20) @(negedge clk);
    endtask

    // Asynchronous reset in the middle of ECHO
    task automatic test_reset_mid_echo();
        int rd, w, tl, seen;
        dist_cm = 9'd10;
        trig = 1'b1;
        repeat (24) @(negedge clk);
        trig = 1'b0;
        rd = 0;
        while (!echo && rd < 40) begin
            @(negedge clk);
            rd++;
        end
        repeat (50) @(negedge clk);
        checks++;
        if (echo !== 1'b1) begin
            $display("FAIL rst_pre_echo: got %b want 1", echo);
            failures++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (echo !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rst_mid_echo: echo=%b busy=%b want 0 0",
                     echo, busy);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (echo !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL rst_quiet: got %0d want 0", seen);
            failures++;
        end
        run_meas(24, rd, w, tl);
        checks++;
        if (w != 1160) begin
            $display("FAIL rst_new_echo: got %0d want 1160", w);
            failures++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_stats();
`ifdef ECHO_STATS_EN
        int rd, w, tl;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        dist_cm = 9'd1;
        repeat (3) begin
            run_meas(24, rd, w, tl);
            repeat (5) @(negedge clk);
        end
        checks++;
        if (echo_cnt !== 16'd3) begin
            $display("FAIL stats_count: got %0d want 3", echo_cnt);
            failures++;
        end
        force dut.echo_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.echo_cnt;
        run_meas(24, rd, w, tl);
        checks++;
        if (echo_cnt !== 16'd0) begin
            $display("FAIL stats_wrap: got %0d want 0", echo_cnt);
            failures++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trig_min();
        test_short();
        test_timeout();
        test_mid_echo();
        test_rearm();
        test_trig_hold();
        test_reset_mid_echo();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
